// File: rtl/rob_entry_structs.sv
// rtl/rob_entry_structs.sv - shared ROB commit types: regfile write bus, commit FSM states.
package rob_entry_structs;

   localparam int RF_XLEN      = 32;
   localparam int RF_ROB_IDX_W = 5;
   localparam int RF_REG_IDX_W = 5;
   localparam int ROB_DEPTH    = 32;

   typedef struct packed {
      logic                    valid;
      logic [RF_XLEN-1:0]      value;
      logic [RF_ROB_IDX_W-1:0] rob_idx;
      logic [RF_REG_IDX_W-1:0] regfile_idx;
   } rob_to_regfile;

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      ST_WAIT    = 2'd1,
      FLUSH_HOLD = 2'd2
   } commit_state_t;

endpackage

// File: rtl/rob_commit_ctrl.sv
// rtl/rob_commit_ctrl.sv - in-order ROB retirement: regfile writeback, store-commit handshake, mispredict flush.
module rob_commit_ctrl
   import rob_entry_structs::*;
#(
   parameter int XLEN         = RF_XLEN,
   parameter int ROB_IDX_W    = RF_ROB_IDX_W,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 head_valid,
   input  logic                 head_done,
   input  logic [ROB_IDX_W-1:0] head_rob_idx,
   input  logic [4:0]           head_dr,
   input  logic [XLEN-1:0]      head_value,
   input  logic                 head_is_st,
   input  logic                 head_mispredict,
   input  logic [XLEN-1:0]      head_redirect_pc,
   input  logic                 st_commit_ack,
   output logic                 commit,
   output rob_to_regfile        rf_commit,
   output logic                 st_commit_req,
   output logic                 flush,
   output logic [XLEN-1:0]      redirect_pc,
   output logic [31:0]          retired_count
);

   localparam int HOLD_W = $clog2(FLUSH_CYCLES + 1);

   commit_state_t     r_state;
   logic [HOLD_W-1:0] r_hold;
   rob_to_regfile     r_rf_commit;
   logic              r_st_req;
   logic              r_flush;
   logic [XLEN-1:0]   r_redirect_pc;
   logic [31:0]       r_retired_count;
   logic              w_head_ready;
   logic              w_commit;

   assign w_head_ready = head_valid & head_done;

   // A head flagged both store and mispredict is treated as a store.
   always_comb begin
      w_commit = 1'b0;
      if (!rst) begin
         case (r_state)
            RUN:     w_commit = w_head_ready & ~head_is_st;
            ST_WAIT: w_commit = st_commit_ack;
            default: w_commit = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state         <= RUN;
         r_hold          <= '0;
         r_rf_commit     <= '0;
         r_st_req        <= 1'b0;
         r_flush         <= 1'b0;
         r_redirect_pc   <= '0;
         r_retired_count <= '0;
      end else begin
         r_flush     <= 1'b0;
         r_rf_commit <= '0;
         if (w_commit) begin
            r_retired_count <= r_retired_count + 32'd1;
         end
         case (r_state)
            RUN: begin
               if (w_head_ready) begin
                  if (head_is_st) begin
                     r_st_req <= 1'b1;
                     r_state  <= ST_WAIT;
                  end else begin
                     r_rf_commit.valid       <= (head_dr != 5'd0);
                     r_rf_commit.value       <= head_value;
                     r_rf_commit.rob_idx     <= head_rob_idx;
                     r_rf_commit.regfile_idx <= head_dr;
                     if (head_mispredict) begin
                        r_flush       <= 1'b1;
                        r_redirect_pc <= head_redirect_pc;
                        r_hold        <= HOLD_W'(FLUSH_CYCLES);
                        r_state       <= FLUSH_HOLD;
                     end
                  end
               end
            end
            ST_WAIT: begin
               if (st_commit_ack) begin
                  r_st_req <= 1'b0;
                  r_state  <= RUN;
               end
            end
            FLUSH_HOLD: begin
               // The head is ignored for FLUSH_CYCLES cycles while the ROB drains.
               if (r_hold <= HOLD_W'(1)) begin
                  r_state <= RUN;
               end
               r_hold <= r_hold - HOLD_W'(1);
            end
            default: r_state <= RUN;
         endcase
      end
   end

   a_store_not_branch: assert property (@(posedge clk) disable iff (rst)
      !(r_state == RUN && w_head_ready && head_is_st && head_mispredict));

   assign commit        = w_commit;
   assign rf_commit     = r_rf_commit;
   assign st_commit_req = r_st_req;
   assign flush         = r_flush;
   assign redirect_pc   = r_redirect_pc;
   assign retired_count = r_retired_count;

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// tb/tb_rob_commit_ctrl.sv - scoreboard bench for rob_commit_ctrl with a queue-based retirement model.
module tb_rob_commit_ctrl;
   import rob_entry_structs::*;

   localparam int FC = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          head_valid, head_done, head_is_st, head_mispredict, st_commit_ack;
   logic [4:0]    head_rob_idx, head_dr;
   logic [31:0]   head_value, head_redirect_pc;
   logic          commit, st_commit_req, flush;
   rob_to_regfile rf_commit;
   logic [31:0]   redirect_pc, retired_count;

   rob_commit_ctrl #(.XLEN(32), .ROB_IDX_W(5), .FLUSH_CYCLES(FC)) dut (
      .clk(clk), .rst(rst),
      .head_valid(head_valid), .head_done(head_done), .head_rob_idx(head_rob_idx),
      .head_dr(head_dr), .head_value(head_value), .head_is_st(head_is_st),
      .head_mispredict(head_mispredict), .head_redirect_pc(head_redirect_pc),
      .st_commit_ack(st_commit_ack), .commit(commit), .rf_commit(rf_commit),
      .st_commit_req(st_commit_req), .flush(flush), .redirect_pc(redirect_pc),
      .retired_count(retired_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int cyc; logic [31:0] value; logic [4:0] idx; logic [4:0] dr; } rf_exp_t;
   typedef struct { int cyc; logic [31:0] pc; } fl_exp_t;
   typedef struct { int cyc; logic commit; logic st_req; logic [31:0] retired; } cy_exp_t;

   rf_exp_t rf_q[$];
   fl_exp_t fl_q[$];
   cy_exp_t cy_q[$];

   int n_vec = 0;
   int n_err = 0;

   // Reference model: 0 = retiring, 1 = waiting on store ack, 2 = flush shadow.
   int          m_mode = 0;
   int          m_hold = 0;
   logic        m_st_req = 1'b0;
   logic [31:0] m_retired = 32'd0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic v, input logic d, input logic [4:0] idx,
                       input logic [4:0] dr, input logic [31:0] val, input logic st,
                       input logic mp, input logic [31:0] pc, input logic ack);
      cy_exp_t e;
      rf_exp_t re;
      fl_exp_t fe;
      @(posedge clk);
      #1;
      rst = r; head_valid = v; head_done = d; head_rob_idx = idx; head_dr = dr;
      head_value = val; head_is_st = st; head_mispredict = mp; head_redirect_pc = pc;
      st_commit_ack = ack;
      e.cyc = cyc; e.st_req = m_st_req; e.retired = m_retired; e.commit = 1'b0;
      if (r) begin
         m_mode = 0; m_st_req = 1'b0; m_retired = 32'd0;
      end else if (m_mode == 0) begin
         if (v && d) begin
            if (st) begin
               m_mode = 1; m_st_req = 1'b1;
            end else begin
               e.commit = 1'b1;
               if (dr != 5'd0) begin
                  re.cyc = cyc + 1; re.value = val; re.idx = idx; re.dr = dr;
                  rf_q.push_back(re);
               end
               if (mp) begin
                  fe.cyc = cyc + 1; fe.pc = pc;
                  fl_q.push_back(fe);
                  m_mode = 2; m_hold = FC;
               end
            end
         end
      end else if (m_mode == 1) begin
         if (ack) begin
            e.commit = 1'b1; m_mode = 0; m_st_req = 1'b0;
         end
      end else begin
         m_hold--;
         if (m_hold == 0) m_mode = 0;
      end
      cy_q.push_back(e);
      if (e.commit) m_retired = m_retired + 32'd1;
   endtask

   task automatic idle(input logic ack);
      step(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0, ack);
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (cy_q.size() > 0 && cy_q[0].cyc == cyc) begin
            cy_exp_t e;
            e = cy_q.pop_front();
            check("commit", 64'(commit), 64'(e.commit));
            check("st_commit_req", 64'(st_commit_req), 64'(e.st_req));
            check("retired_count", 64'(retired_count), 64'(e.retired));
         end
         while (rf_q.size() > 0 && rf_q[0].cyc < cyc) begin
            void'(rf_q.pop_front());
            n_vec++; n_err++;
            $display("FAIL rf_commit missing (cycle %0d): got valid 0, expected valid 1", cyc);
         end
         if (rf_commit.valid) begin
            if (rf_q.size() == 0 || rf_q[0].cyc != cyc) begin
               n_vec++; n_err++;
               $display("FAIL rf_commit unexpected (cycle %0d): got %0h, expected valid 0", cyc, rf_commit);
            end else begin
               rf_exp_t x;
               x = rf_q.pop_front();
               check("rf_commit", 64'(rf_commit), 64'({1'b1, x.value, x.idx, x.dr}));
            end
         end
         while (fl_q.size() > 0 && fl_q[0].cyc < cyc) begin
            void'(fl_q.pop_front());
            n_vec++; n_err++;
            $display("FAIL flush missing (cycle %0d): got 0, expected 1", cyc);
         end
         if (flush) begin
            if (fl_q.size() == 0 || fl_q[0].cyc != cyc) begin
               n_vec++; n_err++;
               $display("FAIL flush unexpected (cycle %0d): got 1, expected 0", cyc);
            end else begin
               fl_exp_t f;
               f = fl_q.pop_front();
               check("redirect_pc", 64'(redirect_pc), 64'(f.pc));
            end
         end
      end
   end

   initial begin
      rst = 1'b1; head_valid = 1'b0; head_done = 1'b0; head_rob_idx = '0; head_dr = '0;
      head_value = '0; head_is_st = 1'b0; head_mispredict = 1'b0; head_redirect_pc = '0;
      st_commit_ack = 1'b0;
      @(posedge clk);
      step(1'b1, 1'b1, 1'b1, 5'd3, 5'd7, 32'h77, 1'b0, 1'b0, 32'd0, 1'b0);
      @(negedge clk);
      #1;
      check("reset rf_commit", 64'(rf_commit), 64'd0);
      check("reset flush", 64'(flush), 64'd0);
      check("reset redirect_pc", 64'(redirect_pc), 64'd0);

      // Back-to-back retirement.
      step(1'b0, 1'b1, 1'b1, 5'd4, 5'd1, 32'hA, 1'b0, 1'b0, 32'd0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 5'd5, 5'd2, 32'hB, 1'b0, 1'b0, 32'd0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 5'd6, 5'd3, 32'hC, 1'b0, 1'b0, 32'd0, 1'b0);
      idle(1'b0);
      @(negedge clk);
      #1;
      check("retired after three", 64'(retired_count), 64'd3);

      // Store with ack on the third request cycle.
      step(1'b0, 1'b1, 1'b1, 5'd7, 5'd4, 32'h5, 1'b1, 1'b0, 32'd0, 1'b1);
      step(1'b0, 1'b1, 1'b1, 5'd7, 5'd4, 32'h5, 1'b1, 1'b0, 32'd0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 5'd7, 5'd4, 32'h5, 1'b1, 1'b0, 32'd0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 5'd7, 5'd4, 32'h5, 1'b1, 1'b0, 32'd0, 1'b1);
      idle(1'b1);

      // Mispredict; the following done heads fall in the flush shadow.
      step(1'b0, 1'b1, 1'b1, 5'd9, 5'd1, 32'h104, 1'b0, 1'b1, 32'h2000, 1'b0);
      step(1'b0, 1'b1, 1'b1, 5'd10, 5'd2, 32'h11, 1'b0, 1'b0, 32'd0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 5'd10, 5'd2, 32'h11, 1'b0, 1'b0, 32'd0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 5'd10, 5'd2, 32'h11, 1'b0, 1'b0, 32'd0, 1'b0);

      // x0 destination, then a stale done entry.
      step(1'b0, 1'b1, 1'b1, 5'd12, 5'd0, 32'h55, 1'b0, 1'b0, 32'd0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 5'd13, 5'd5, 32'h66, 1'b0, 1'b0, 32'd0, 1'b0);

      // Reset in the middle of a store wait, then a stray ack.
      step(1'b0, 1'b1, 1'b1, 5'd14, 5'd6, 32'h1, 1'b1, 1'b0, 32'd0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 5'd14, 5'd6, 32'h1, 1'b1, 1'b0, 32'd0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 5'd14, 5'd6, 32'h1, 1'b1, 1'b0, 32'd0, 1'b0);
      idle(1'b1);
      idle(1'b1);

      // Reset during the flush shadow.
      step(1'b0, 1'b1, 1'b1, 5'd15, 5'd8, 32'h3, 1'b0, 1'b1, 32'h4000, 1'b0);
      step(1'b1, 1'b1, 1'b1, 5'd16, 5'd8, 32'h3, 1'b0, 1'b0, 32'd0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 5'd16, 5'd9, 32'h9, 1'b0, 1'b0, 32'd0, 1'b0);

      // Counter wrap.
      idle(1'b0);
      @(negedge clk);
      #1;
      force dut.r_retired_count = 32'hFFFF_FFFF;
      #1;
      release dut.r_retired_count;
      m_retired = 32'hFFFF_FFFF;
      step(1'b0, 1'b1, 1'b1, 5'd17, 5'd3, 32'h21, 1'b0, 1'b0, 32'd0, 1'b0);
      idle(1'b0);
      @(negedge clk);
      #1;
      check("retired wrap", 64'(retired_count), 64'd0);

      for (int i = 0; i < 400; i++) begin
         logic r, v, d, st, mp, ack;
         r   = ($urandom_range(0, 49) == 0);
         v   = ($urandom_range(0, 3) != 0);
         d   = ($urandom_range(0, 3) != 0);
         st  = ($urandom_range(0, 4) == 0);
         mp  = !st && ($urandom_range(0, 5) == 0);
         ack = ($urandom_range(0, 2) == 0);
         step(r, v, d, 5'($urandom), 5'($urandom), $urandom, st, mp, $urandom, ack);
      end
      for (int i = 0; i < 5; i++) idle(1'b1);
      @(negedge clk);
      #2;
      check("rf queue drained", 64'(rf_q.size()), 64'd0);
      check("flush queue drained", 64'(fl_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
